// File: rtl/hex_display_scan.sv
// hex_display_scan: 8-digit multiplexed 7-segment scanner for the HEX0 bus.
// A loaded value waits in a pending register and is committed only at a
// scan-frame wrap, so a frame never mixes two values.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero nibble of the committed value (digit 0 always shown).
module hex_display_scan #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic                  load_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  pend_o,
    output logic                  frame_o
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic                 POL      = (ACTIVE_LOW != 0);

    logic [DIV_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_W-1:0]    disp;
    logic [DATA_W-1:0]    pending;

    logic                 tick_c;
    logic                 wrap_c;
    logic [3:0]           nib_c;
    logic [6:0]           code_c;
    logic [6:0]           seg_c;
    logic [DIGITS-1:0]    an_c;
    logic                 blank_c;

    // Digit tick at prescaler terminal count; frame wrap on the last digit
    always_comb begin
        tick_c = (cnt == CNT_MAX);
        wrap_c = tick_c && (idx == IDX_LAST);
    end

    // Free-running prescaler and digit index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
            if (tick_c) begin
                idx <= wrap_c ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Pending capture and frame-boundary commit; a load on the wrap cycle
    // commits the old pending value and queues the new one for next frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp    <= '0;
            pending <= '0;
            pend_o  <= 1'b0;
        end else begin
            if (wrap_c && pend_o) begin
                disp   <= pending;
                pend_o <= 1'b0;
            end
            if (load_i) begin
                pending <= data_i;
                pend_o  <= 1'b1;
            end
        end
    end

    // Select current nibble, one-hot digit enable and blanking decision
    always_comb begin
        nib_c   = 4'h0;
        an_c    = '0;
        blank_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                nib_c   = disp[4*i +: 4];
                an_c[i] = 1'b1;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic [IDX_W-1:0] msd;
            msd = '0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (disp[4*i +: 4] != 4'h0) begin
                    msd = IDX_W'(i);
                end
            end
            blank_c = (idx > msd);
        end
`else
        blank_c = 1'b0;
`endif
    end

    // Hex to active-high segment code, bit0 = a
    always_comb begin
        code_c = 7'h00;
        case (nib_c)
            4'h0: code_c = 7'h3F;
            4'h1: code_c = 7'h06;
            4'h2: code_c = 7'h5B;
            4'h3: code_c = 7'h4F;
            4'h4: code_c = 7'h66;
            4'h5: code_c = 7'h6D;
            4'h6: code_c = 7'h7D;
            4'h7: code_c = 7'h07;
            4'h8: code_c = 7'h7F;
            4'h9: code_c = 7'h6F;
            4'hA: code_c = 7'h77;
            4'hB: code_c = 7'h7C;
            4'hC: code_c = 7'h39;
            4'hD: code_c = 7'h5E;
            4'hE: code_c = 7'h79;
            4'hF: code_c = 7'h71;
            default: code_c = 7'h00;
        endcase
        seg_c = blank_c ? 7'h00 : code_c;
    end

    // Registered display outputs with selectable polarity
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_o    <= {DIGITS{POL}};
            seg_o   <= {7{POL}};
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_c ^ {DIGITS{POL}};
            seg_o   <= seg_c ^ {7{POL}};
            frame_o <= wrap_c;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan at DIV_WIDTH=2, DIGITS=8, ACTIVE_LOW=1.
// Reference model tracks elapsed cycles since reset plus committed/pending values.
module tb_hex_display_scan;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        pend_o;
    logic        frame_o;

    hex_display_scan #(.DIV_WIDTH(2), .DIGITS(8), .ACTIVE_LOW(1)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .load_i (load_i),
        .an_o   (an_o),
        .seg_o  (seg_o),
        .pend_o (pend_o),
        .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // model state
    int          n = 0;          // non-reset edges since last reset
    int          cyc = 0;
    int          last_frame = -1;
    logic [31:0] m_disp = '0;
    logic [31:0] m_pending = '0;
    logic        m_pend = 1'b0;
    logic [31:0] shown_disp = '0;
    int          shown_d = -1;

    typedef struct {
        logic [31:0] data;
        int          digit;
        logic [6:0]  seg;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_code(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d);
        logic [31:0] sh;
        sh = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && sh == 32'd0) return 7'h7F;
`endif
        return ~hex_code(sh[3:0]);
    endfunction

    // One clock: drive inputs, advance model, compare all outputs
    task automatic step(input logic r, input logic ld, input logic [31:0] d);
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_frame;
        int         dig;
        rst_i  = r;
        load_i = ld;
        data_i = ld ? d : $urandom;
        @(posedge clk_i);
        #1;
        cyc++;
        if (r) begin
            n = 0; m_disp = '0; m_pending = '0; m_pend = 1'b0;
            e_an = 8'hFF; e_seg = 7'h7F; e_frame = 1'b0;
            last_frame = -1; shown_d = -1; shown_disp = '0;
        end else begin
            dig        = (n / 4) % 8;
            e_an       = ~(8'd1 << dig);
            e_seg      = exp_seg(m_disp, dig);
            e_frame    = (n % 32 == 31);
            shown_disp = m_disp;
            shown_d    = dig;
            if (e_frame && m_pend) begin
                m_disp = m_pending;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_pending = d;
                m_pend    = 1'b1;
            end
            n++;
        end
        chk("an_o", 32'(an_o), 32'(e_an));
        chk("seg_o", 32'(seg_o), 32'(e_seg));
        chk("pend_o", 32'(pend_o), 32'(m_pend));
        chk("frame_o", 32'(frame_o), 32'(e_frame));
        if (!r && frame_o === 1'b1) begin
            if (last_frame >= 0) chk("frame_period", 32'(cyc - last_frame), 32'd32);
            last_frame = cyc;
        end
        rst_i  = 1'b0;
        load_i = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 64 && (n % 32) != ph; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    // Load a value, then wait until it is displayed on the requested digit
    task automatic show_digit(input vec_t v);
        bit found;
        found = 0;
        step(1'b0, 1'b1, v.data);
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b0, 1'b0, 32'd0);
            if (shown_disp == v.data && shown_d == v.digit) found = 1;
        end
        if (found) begin
            chk($sformatf("vec_%h_d%0d", v.data, v.digit), 32'(seg_o), 32'(v.seg));
        end else begin
            checks++;
            failures++;
            $display("FAIL vec_timeout actual=none required=%h on digit %0d", v.data, v.digit);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] dt, input int dg, input logic [6:0] sg);
        vec_t v;
        v.data = dt; v.digit = dg; v.seg = sg;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(32'h1234ABCD, 0, 7'h21));
        vecs.push_back(mk(32'h1234ABCD, 7, 7'h79));
        vecs.push_back(mk(32'h1234ABCD, 4, 7'h19));
        vecs.push_back(mk(32'h1234ABCD, 2, 7'h03));
        vecs.push_back(mk(32'h89ABCDEF, 0, 7'h0E));
        vecs.push_back(mk(32'h89ABCDEF, 1, 7'h06));
        vecs.push_back(mk(32'h89ABCDEF, 6, 7'h10));
        vecs.push_back(mk(32'h89ABCDEF, 7, 7'h00));
        vecs.push_back(mk(32'h76543210, 0, 7'h40));
        vecs.push_back(mk(32'h76543210, 2, 7'h24));
        vecs.push_back(mk(32'h76543210, 3, 7'h30));
        vecs.push_back(mk(32'h76543210, 5, 7'h12));
        vecs.push_back(mk(32'h76543210, 6, 7'h02));
        vecs.push_back(mk(32'h76543210, 7, 7'h78));
        vecs.push_back(mk(32'h000000A0, 0, 7'h40));
        vecs.push_back(mk(32'h000000A0, 1, 7'h08));
`ifdef LEADING_ZERO_BLANK_EN
        vecs.push_back(mk(32'h000000A0, 2, 7'h7F));
        vecs.push_back(mk(32'h000000A0, 7, 7'h7F));
        vecs.push_back(mk(32'h00000000, 0, 7'h40));
        vecs.push_back(mk(32'h00000000, 3, 7'h7F));
`else
        vecs.push_back(mk(32'h000000A0, 2, 7'h40));
        vecs.push_back(mk(32'h000000A0, 7, 7'h40));
        vecs.push_back(mk(32'h00000000, 0, 7'h40));
        vecs.push_back(mk(32'h00000000, 3, 7'h40));
`endif

        // Reset held 3 cycles, then first output after release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("first_an", 32'(an_o), 32'h0000_00FE);
        chk("first_seg", 32'(seg_o), 32'h0000_0040);

        // Free run: frame period and digit walk
        run(80);

        // Mid-frame load keeps display, pend set
        wait_phase(10);
        step(1'b0, 1'b1, 32'h1234ABCD);
        chk("mid_pend", 32'(pend_o), 32'd1);
        wait_phase(0);
        chk("post_wrap_pend", 32'(pend_o), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("s3_digit0", 32'(seg_o), 32'h21);
        run(28);
        chk("s3_digit7", 32'(seg_o), 32'h79);

        // Table-driven digit vectors
        foreach (vecs[i]) show_digit(vecs[i]);

        // Load coinciding with wrap: old pending committed, new one queued
        wait_phase(20);
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_phase(31);
        step(1'b0, 1'b1, 32'h0000_0011);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("s4_allF", 32'(seg_o), 32'h0E);
            chk("s4_pend", 32'(pend_o), 32'd1);
            run(3);
        end
        step(1'b0, 1'b0, 32'd0);
        chk("s4_d0", 32'(seg_o), 32'h79);
        chk("s4_pend_clr", 32'(pend_o), 32'd0);
        run(3);
        step(1'b0, 1'b0, 32'd0);
        chk("s4_d1", 32'(seg_o), 32'h79);

        // Reset at idx 5 with a pending value discards it
        wait_phase(1);
        step(1'b0, 1'b1, 32'h5555_5555);
        wait_phase(21);
        step(1'b1, 1'b0, 32'd0);
        chk("s6_an", 32'(an_o), 32'hFF);
        chk("s6_seg", 32'(seg_o), 32'h7F);
        chk("s6_pend", 32'(pend_o), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("s6_rel_an", 32'(an_o), 32'hFE);
        chk("s6_rel_seg", 32'(seg_o), 32'h40);
        run(70);

        // Randomized loads and occasional resets against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 9) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
